// File: rtl/core_inst_pkg.sv
// core_inst_pkg: instruction word layout, tile geometry and sequencer states
// shared by the sequencer, its address generator and anything decoding inst.
package core_inst_pkg;

    // Tile geometry
    localparam int unsigned COL      = 8;
    localparam int unsigned ROW      = 8;
    localparam int unsigned LEN_NIJ  = 36;
    localparam int unsigned LEN_ONIJ = 16;
    localparam int unsigned LEN_KIJ  = 9;
    localparam int unsigned IN_W     = 6;
    localparam int unsigned OUT_W    = 4;
    localparam int unsigned K_W      = 3;
    localparam int unsigned GAP_CYC  = 10;

    // Instruction word layout
    localparam int unsigned INST_W     = 47;
    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned CEN_XMEM   = 46;
    localparam int unsigned WEN_XMEM   = 45;
    localparam int unsigned A_XMEM_LSB = 34;
    localparam int unsigned ACC        = 33;
    localparam int unsigned CEN_PMEM   = 32;
    localparam int unsigned WEN_PMEM   = 31;
    localparam int unsigned A_PMEM_LSB = 20;
    localparam int unsigned CEN_WMEM   = 19;
    localparam int unsigned WEN_WMEM   = 18;
    localparam int unsigned A_WMEM_LSB = 7;
    localparam int unsigned OFIFO_RD   = 6;
    localparam int unsigned IFIFO_WR   = 5;
    localparam int unsigned IFIFO_RD   = 4;
    localparam int unsigned L0_RD      = 3;
    localparam int unsigned L0_WR      = 2;
    localparam int unsigned EXECUTE    = 1;
    localparam int unsigned LOAD       = 0;

    // All memories disabled and not writing, every strobe and address zero
    localparam logic [INST_W-1:0] INST_IDLE = 47'h6001_800C_0000;

    // In-state counter width and the last counter value of each timed state
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_W_FETCH   = 8'(COL);
    localparam logic [CNT_W-1:0] LAST_W_DRAIN   = 8'(ROW + COL - 2);
    localparam logic [CNT_W-1:0] LAST_W_GAP     = 8'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_X_FETCH   = 8'(LEN_NIJ);
    localparam logic [CNT_W-1:0] LAST_EXEC      = 8'(LEN_NIJ + ROW + COL - 2);
    localparam logic [CNT_W-1:0] LAST_EXEC_TAIL = 8'(1);
    localparam logic [CNT_W-1:0] LAST_OFIFO_RD  = 8'(LEN_NIJ - 1);
    localparam logic [CNT_W-1:0] LAST_ACC_RD    = 8'(LEN_KIJ);

    localparam logic [3:0] KIJ_LAST  = 4'(LEN_KIJ - 1);
    localparam logic [4:0] ONIJ_LAST = 5'(LEN_ONIJ - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_FETCH,
        S_W_DRAIN,
        S_W_GAP,
        S_X_FETCH,
        S_EXEC,
        S_EXEC_TAIL,
        S_OFIFO_RD,
        S_ACC_RD,
        S_ACC_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/acc_addr_gen.sv
// acc_addr_gen: psum address of kernel tap k contributing to output pixel o.
// Each kij pass wrote its psums at k*len_nij + input pixel index, and output
// pixel o with tap k reads input pixel (o/out_w + k/k_w, o%out_w + k%k_w).
module acc_addr_gen
    import core_inst_pkg::*;
(
    input  logic [4:0]        onij,
    input  logic [3:0]        kij,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] NIJ_A = ADDR_W'(LEN_NIJ);
    localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0] K_A   = ADDR_W'(K_W);

    logic [ADDR_W-1:0] o_ext;
    logic [ADDR_W-1:0] k_ext;

    // Row/column decomposition of both indices, summed into the flat address
    always_comb begin
        o_ext = {6'd0, onij};
        k_ext = {7'd0, kij};
        addr  = k_ext * NIJ_A
              + (o_ext / OUT_A + k_ext / K_A) * IN_A
              + (o_ext % OUT_A) + (k_ext % K_A);
    end

endmodule

// File: rtl/core_inst_seq.sv
// core_inst_seq: runs one 3x3 convolution tile (9 kij passes, then the psum
// accumulation per output pixel) by driving every field of the core's inst bus.
// The FSM state leads the registered inst word by one cycle.
module core_inst_seq
    import core_inst_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              out_valid,
    output logic              acc_clr,
    output logic              done
);

    state_t            state;
    state_t            state_after;
    logic [CNT_W-1:0]  t;
    logic [CNT_W-1:0]  t_last;
    logic [3:0]        kij;
    logic [4:0]        onij;
    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] ofifo_addr;
    logic [INST_W-1:0] inst_next;

    acc_addr_gen u_acc_addr (
        .onij (onij),
        .kij  (t[3:0]),
        .addr (acc_addr)
    );

    assign ofifo_addr = {7'd0, kij} * ADDR_W'(LEN_NIJ) + {3'd0, t};

    // Length and successor of each fixed-length state
    always_comb begin
        t_last      = '0;
        state_after = S_IDLE;
        unique case (state)
            S_W_FETCH:   begin t_last = LAST_W_FETCH;   state_after = S_W_DRAIN;   end
            S_W_DRAIN:   begin t_last = LAST_W_DRAIN;   state_after = S_W_GAP;     end
            S_W_GAP:     begin t_last = LAST_W_GAP;     state_after = S_X_FETCH;   end
            S_X_FETCH:   begin t_last = LAST_X_FETCH;   state_after = S_EXEC;      end
            S_EXEC:      begin t_last = LAST_EXEC;      state_after = S_EXEC_TAIL; end
            S_EXEC_TAIL: begin t_last = LAST_EXEC_TAIL; state_after = S_OFIFO_RD;  end
            S_ACC_RD:    begin t_last = LAST_ACC_RD;    state_after = S_ACC_OUT;   end
            default:     begin t_last = '0;             state_after = S_IDLE;      end
        endcase
    end

    // Instruction word for the current state and counter, registered next edge
    always_comb begin
        inst_next = INST_IDLE;
        unique case (state)
            S_W_FETCH: begin
                if (t < LAST_W_FETCH) begin
                    inst_next[CEN_WMEM] = 1'b0;
                    inst_next[A_WMEM_LSB +: ADDR_W] = {3'd0, t};
                end
                if (t != '0) inst_next[IFIFO_WR] = 1'b1;
                inst_next[LOAD] = 1'b1;
            end
            S_W_DRAIN: begin
                inst_next[IFIFO_RD] = 1'b1;
                inst_next[LOAD]     = 1'b1;
            end
            S_X_FETCH: begin
                if (t < LAST_X_FETCH) begin
                    inst_next[CEN_XMEM] = 1'b0;
                    inst_next[A_XMEM_LSB +: ADDR_W] = {3'd0, t};
                end
                if (t != '0) inst_next[L0_WR] = 1'b1;
            end
            S_EXEC: begin
                inst_next[L0_RD]   = 1'b1;
                inst_next[EXECUTE] = 1'b1;
            end
            S_OFIFO_RD: begin
                inst_next[A_PMEM_LSB +: ADDR_W] = ofifo_addr;
                if (ofifo_valid) begin
                    inst_next[OFIFO_RD] = 1'b1;
                    inst_next[CEN_PMEM] = 1'b0;
                    inst_next[WEN_PMEM] = 1'b0;
                end
            end
            S_ACC_RD: begin
                if (t < LAST_ACC_RD) begin
                    inst_next[CEN_PMEM] = 1'b0;
                    inst_next[A_PMEM_LSB +: ADDR_W] = acc_addr;
                end
                if (t != '0) inst_next[ACC] = 1'b1;
            end
            default: inst_next = INST_IDLE;
        endcase
    end

    // Sequencer FSM with pass/pixel counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            t         <= '0;
            kij       <= '0;
            onij      <= '0;
            inst      <= INST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            acc_clr   <= 1'b0;
            done      <= 1'b0;
        end else begin
            inst      <= inst_next;
            busy      <= (state != S_IDLE);
            out_valid <= (state == S_ACC_OUT);
            acc_clr   <= (state == S_ACC_OUT);
            done      <= (state == S_DONE);
            unique case (state)
                S_IDLE: begin
                    // busy is still high in the done cycle, so a start there is dropped
                    if (start && !busy) begin
                        state <= S_W_FETCH;
                        t     <= '0;
                        kij   <= '0;
                        onij  <= '0;
                    end
                end
                S_OFIFO_RD: begin
                    if (ofifo_valid) begin
                        if (t == LAST_OFIFO_RD) begin
                            t   <= '0;
                            kij <= kij + 4'd1;
                            if (kij == KIJ_LAST) begin
                                state <= S_ACC_RD;
                                onij  <= '0;
                            end else begin
                                state <= S_W_FETCH;
                            end
                        end else begin
                            t <= t + 8'd1;
                        end
                    end
                end
                S_ACC_OUT: begin
                    t    <= '0;
                    onij <= onij + 5'd1;
                    state <= (onij == ONIJ_LAST) ? S_DONE : S_ACC_RD;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    if (t == t_last) begin
                        t     <= '0;
                        state <= state_after;
                    end else begin
                        t <= t + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: checks the full inst trace of complete tiles against a
// phase-by-phase reference list, with clean, directed-stall and random-stall
// ofifo_valid, ignored start pulses and a mid-run reset.
module tb_core_inst_seq;
    import core_inst_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              out_valid;
    logic              acc_clr;
    logic              done;

    int checks_total;
    int checks_passed;
    int checks_failed;

    typedef struct {
        logic [INST_W-1:0] word;
        bit                beat;
        bit                outv;
        bit                dn;
    } exp_t;

    exp_t expq[$];

    core_inst_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .out_valid   (out_valid),
        .acc_clr     (acc_clr),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [INST_W-1:0] observed,
                               input logic [INST_W-1:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        checks_total++;
        assert (observed == expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive inputs at a falling edge and advance to the next falling edge
    task automatic applyStimulus(input logic s, input logic ov);
        start       = s;
        ofifo_valid = ov;
        @(negedge clk);
    endtask

    function automatic exp_t blankEntry();
        exp_t e;
        e.word = INST_IDLE;
        e.beat = 1'b0;
        e.outv = 1'b0;
        e.dn   = 1'b0;
        return e;
    endfunction

    function automatic int refAddr(input int o, input int k);
        int r;
        int c;
        r = o / OUT_W + k / K_W;
        c = o % OUT_W + k % K_W;
        return k * LEN_NIJ + r * IN_W + c;
    endfunction

    // Expected inst word of every cycle of an unstalled tile, phase by phase
    function automatic void buildExpected();
        exp_t e;
        expq.delete();
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int t = 0; t <= COL; t++) begin
                e = blankEntry();
                if (t < COL) begin
                    e.word[CEN_WMEM] = 1'b0;
                    e.word[A_WMEM_LSB +: ADDR_W] = 11'(t);
                end
                if (t >= 1) e.word[IFIFO_WR] = 1'b1;
                e.word[LOAD] = 1'b1;
                expq.push_back(e);
            end
            for (int t = 0; t < ROW + COL - 1; t++) begin
                e = blankEntry();
                e.word[IFIFO_RD] = 1'b1;
                e.word[LOAD]     = 1'b1;
                expq.push_back(e);
            end
            for (int t = 0; t < GAP_CYC; t++) expq.push_back(blankEntry());
            for (int t = 0; t <= LEN_NIJ; t++) begin
                e = blankEntry();
                if (t < LEN_NIJ) begin
                    e.word[CEN_XMEM] = 1'b0;
                    e.word[A_XMEM_LSB +: ADDR_W] = 11'(t);
                end
                if (t >= 1) e.word[L0_WR] = 1'b1;
                expq.push_back(e);
            end
            for (int t = 0; t < LEN_NIJ + ROW + COL - 1; t++) begin
                e = blankEntry();
                e.word[L0_RD]   = 1'b1;
                e.word[EXECUTE] = 1'b1;
                expq.push_back(e);
            end
            for (int t = 0; t < 2; t++) expq.push_back(blankEntry());
            for (int b = 0; b < LEN_NIJ; b++) begin
                e = blankEntry();
                e.word[OFIFO_RD] = 1'b1;
                e.word[CEN_PMEM] = 1'b0;
                e.word[WEN_PMEM] = 1'b0;
                e.word[A_PMEM_LSB +: ADDR_W] = 11'(k * LEN_NIJ + b);
                e.beat = 1'b1;
                expq.push_back(e);
            end
        end
        for (int o = 0; o < LEN_ONIJ; o++) begin
            for (int t = 0; t <= LEN_KIJ; t++) begin
                e = blankEntry();
                if (t < LEN_KIJ) begin
                    e.word[CEN_PMEM] = 1'b0;
                    e.word[A_PMEM_LSB +: ADDR_W] = 11'(refAddr(o, t));
                end
                if (t >= 1) e.word[ACC] = 1'b1;
                expq.push_back(e);
            end
            e = blankEntry();
            e.outv = 1'b1;
            expq.push_back(e);
        end
        e = blankEntry();
        e.dn = 1'b1;
        expq.push_back(e);
    endfunction

    // One tile run. mode 0: ofifo_valid high, 1: random, 2: three-cycle stall at
    // beat 10 of kij=2. Returns early after abort_at cycles when abort_at > 0.
    task automatic runTrace(input string tag, input int mode, input int abort_at,
                            input bit poke, output int cycles, output int stalls);
        int                ptr;
        int                stall_left;
        int                bursts;
        logic              ov;
        logic              prev_rd;
        exp_t              e;
        logic [INST_W-1:0] want;
        ptr        = 0;
        cycles     = 0;
        stalls     = 0;
        stall_left = 3;
        bursts     = 0;
        prev_rd    = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkFlag({tag, ":busy_at_start_edge"}, busy, 1'b0);
        checkOutput({tag, ":inst_at_start_edge"}, inst, INST_IDLE);
        while (ptr < expq.size() && cycles < 4000) begin
            ov = 1'b1;
            if (mode == 1) begin
                ov = ($urandom_range(0, 3) != 0);
            end else if (mode == 2 && expq[ptr].beat && stall_left > 0 &&
                         expq[ptr].word[A_PMEM_LSB +: ADDR_W] == 11'd82) begin
                ov = 1'b0;
                stall_left--;
            end
            applyStimulus(poke && ptr == 28, ov);
            start = 1'b0;
            cycles++;
            e = expq[ptr];
            want = e.word;
            if (e.beat && !ov) begin
                want[OFIFO_RD] = 1'b0;
                want[CEN_PMEM] = 1'b1;
                want[WEN_PMEM] = 1'b1;
                stalls++;
            end else begin
                ptr++;
            end
            checkOutput($sformatf("%s:inst@%0d", tag, cycles), inst, want);
            checkFlag($sformatf("%s:busy@%0d", tag, cycles), busy, 1'b1);
            checkFlag($sformatf("%s:out_valid@%0d", tag, cycles), out_valid, e.outv);
            checkFlag($sformatf("%s:acc_clr@%0d", tag, cycles), acc_clr, e.outv);
            checkFlag($sformatf("%s:done@%0d", tag, cycles), done, e.dn);
            if (cycles == 1) begin
                checkFlag({tag, ":first_cen_wmem"}, inst[CEN_WMEM], 1'b0);
                checkCount({tag, ":first_a_wmem"}, int'(inst[A_WMEM_LSB +: ADDR_W]), 0);
                checkFlag({tag, ":first_load"}, inst[LOAD], 1'b1);
                checkFlag({tag, ":first_ififo_wr"}, inst[IFIFO_WR], 1'b0);
            end
            if (mode == 0 && inst[OFIFO_RD] && !prev_rd) begin
                checkCount($sformatf("%s:burst%0d_a_pmem", tag, bursts),
                           int'(inst[A_PMEM_LSB +: ADDR_W]), bursts * LEN_NIJ);
                bursts++;
            end
            prev_rd = inst[OFIFO_RD];
            if (abort_at > 0 && cycles == abort_at) begin
                checkFlag({tag, ":in_exec_before_reset"}, inst[EXECUTE], 1'b1);
                return;
            end
        end
        checkCount({tag, ":trace_complete"}, ptr, expq.size());
        if (mode == 0) checkCount({tag, ":burst_count"}, bursts, LEN_KIJ);
        // start held in the done cycle must not launch a second tile
        applyStimulus(1'b1, 1'b1);
        checkFlag({tag, ":busy_after_done"}, busy, 1'b0);
        checkFlag({tag, ":done_one_cycle"}, done, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkFlag($sformatf("%s:no_rerun_busy%0d", tag, i), busy, 1'b0);
            checkOutput($sformatf("%s:no_rerun_inst%0d", tag, i), inst, INST_IDLE);
        end
    endtask

    initial begin
        int cyc;
        int st;
        checks_total  = 0;
        checks_passed = 0;
        checks_failed = 0;
        reset       = 1'b1;
        start       = 1'b0;
        ofifo_valid = 1'b0;
        $display("[TB] core_inst_seq bench starting");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            checkOutput($sformatf("idle:inst%0d", i), inst, INST_IDLE);
            checkFlag($sformatf("idle:busy%0d", i), busy, 1'b0);
            checkFlag($sformatf("idle:done%0d", i), done, 1'b0);
        end

        buildExpected();

        runTrace("clean", 0, 0, 1'b1, cyc, st);
        checkCount("clean:done_cycle", cyc, 1617);

        runTrace("stall3", 2, 0, 1'b0, cyc, st);
        checkCount("stall3:done_cycle", cyc, 1620);

        runTrace("abort", 0, 4 * 160 + 80, 1'b0, cyc, st);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort:inst_after_reset", inst, INST_IDLE);
        checkFlag("abort:busy_after_reset", busy, 1'b0);
        checkFlag("abort:done_after_reset", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("abort:idle_inst%0d", i), inst, INST_IDLE);
            checkFlag($sformatf("abort:idle_busy%0d", i), busy, 1'b0);
        end

        runTrace("restart", 0, 0, 1'b0, cyc, st);
        checkCount("restart:done_cycle", cyc, 1617);

        runTrace("random", 1, 0, 1'b0, cyc, st);
        checkCount("random:done_cycle", cyc, 1617 + st);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
